attack_responder: RTL and testbench

- Turn-side responder to the game-control FSM.
- Consumes `en_attack_p1`, `en_attack_p2`, `en_attack_random` and `en_check`.
- Produces `end_attack_p1`, `end_attack_p2`, `timeout` and `current_player`.
- Runs the per-turn timeout counter, validates player shot coordinates, and generates the random shot via an LFSR after a timeout.

---
 rtl/attack_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_attack_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_responder.sv
// attack_responder
//   Turn-side responder to the game-control FSM. Runs the per-turn timeout
//   counter, validates player shot coordinates and, after a timeout, picks a
//   random on-board shot from a free-running 6-bit LFSR.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   en_attack_p1/p2        FSM attack-phase enables (p1 wins if both high)
//   en_attack_random       FSM random-attack phase
//   en_check               FSM check phase (observed only)
//   fire_p1/p2             single-cycle fire pulses
//   target[5:0]            shot coordinate, row=[5:3], col=[2:0]
//   end_attack_p1/p2       one-cycle pulse: shot accepted for that player
//   timeout                level: turn time expired
//   current_player[1:0]    01=P1, 10=P2, 00=none
//   attack_row/col[2:0]    latched coordinate of last accepted shot
//   attack_valid           one-cycle pulse alongside end_attack_*
//   seconds_left[4:0]      (TURN_SECONDS_EN only) whole seconds left in turn
//
// Optional feature macro: TURN_SECONDS_EN adds CYCLES_PER_SEC and
// seconds_left. With the macro undefined the port and its logic are absent.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for an attack-phase enable
// ST_WAIT_P1   | player 1 turn, timer running
// ST_WAIT_P2   | player 2 turn, timer running
// ST_TIMED_OUT | turn expired, timeout held until random phase starts
// ST_RANDOM    | drawing LFSR values until one lands on the board

module attack_responder #(
  parameter int         BOARD_N        = 5,
  parameter int         TIMEOUT_CYCLES = 750000000,
  parameter int         CNT_W          = 30,
  parameter logic [5:0] LFSR_SEED      = 6'h2B
`ifdef TURN_SECONDS_EN
  , parameter int       CYCLES_PER_SEC = 50000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_attack_p1,
  input  logic       en_attack_p2,
  input  logic       en_attack_random,
  input  logic       en_check,
  input  logic       fire_p1,
  input  logic       fire_p2,
  input  logic [5:0] target,
  output logic       end_attack_p1,
  output logic       end_attack_p2,
  output logic       timeout,
  output logic [1:0] current_player,
  output logic [2:0] attack_row,
  output logic [2:0] attack_col,
  output logic       attack_valid
`ifdef TURN_SECONDS_EN
  , output logic [4:0] seconds_left
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_P1,
    ST_WAIT_P2,
    ST_TIMED_OUT,
    ST_RANDOM
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Compared at 4 bits so BOARD_N = 8 still admits every 3-bit coordinate.
  localparam logic [3:0]       BOARD_LIM  = 4'(BOARD_N);

  function automatic logic on_board(input logic [5:0] coord);
    return ({1'b0, coord[5:3]} < BOARD_LIM) && ({1'b0, coord[2:0]} < BOARD_LIM);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [5:0]       lfsr;

  // The check phase needs no action here; the input is kept for interface
  // symmetry with the game-control FSM.
  logic unused_en_check;
  assign unused_en_check = en_check;

  // Both WAIT states share one branch; these pick the owning player's inputs.
  logic in_wait;
  logic wait_en;
  logic wait_shot;
  logic timer_done;
  logic wait_stay;

  assign in_wait    = (state == ST_WAIT_P1) || (state == ST_WAIT_P2);
  assign wait_en    = (state == ST_WAIT_P1) ? en_attack_p1 : en_attack_p2;
  assign wait_shot  = ((state == ST_WAIT_P1) ? fire_p1 : fire_p2) && on_board(target);
  assign timer_done = (timer == TIMER_LAST);
  assign wait_stay  = in_wait && wait_en && !wait_shot && !timer_done;

  // x^6 + x^5 + 1, maximal length 63; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      end_attack_p1  <= 1'b0;
      end_attack_p2  <= 1'b0;
      timeout        <= 1'b0;
      current_player <= 2'b00;
      attack_row     <= 3'd0;
      attack_col     <= 3'd0;
      attack_valid   <= 1'b0;
    end else begin
      end_attack_p1 <= 1'b0;
      end_attack_p2 <= 1'b0;
      attack_valid  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en_attack_p1) begin
            state          <= ST_WAIT_P1;
            current_player <= 2'b01;
            timer          <= '0;
          end else if (en_attack_p2) begin
            state          <= ST_WAIT_P2;
            current_player <= 2'b10;
            timer          <= '0;
          end else if (en_attack_random) begin
            state <= ST_RANDOM;
          end
        end

        ST_WAIT_P1, ST_WAIT_P2: begin
          if (!wait_en) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (wait_shot) begin
            // A valid shot on the terminal cycle beats the timeout.
            attack_row    <= target[5:3];
            attack_col    <= target[2:0];
            end_attack_p1 <= (state == ST_WAIT_P1);
            end_attack_p2 <= (state == ST_WAIT_P2);
            attack_valid  <= 1'b1;
            state         <= ST_IDLE;
            timer         <= '0;
          end else if (timer_done) begin
            timeout <= 1'b1;
            state   <= ST_TIMED_OUT;
            timer   <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        ST_TIMED_OUT: begin
          if (en_attack_random) begin
            timeout <= 1'b0;
            state   <= ST_RANDOM;
          end
        end

        ST_RANDOM: begin
          if (!en_attack_random) begin
            state <= ST_IDLE;
          end else if (on_board(lfsr)) begin
            attack_row <= lfsr[5:3];
            attack_col <= lfsr[2:0];
            // With no player recorded yet the random shot is credited to p1.
            if (current_player == 2'b10) begin
              end_attack_p2 <= 1'b1;
            end else begin
              end_attack_p1 <= 1'b1;
            end
            attack_valid <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

`ifdef TURN_SECONDS_EN
  localparam int SECS = (TIMEOUT_CYCLES + CYCLES_PER_SEC - 1) / CYCLES_PER_SEC;
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CYCLES_PER_SEC - 1);

  logic [CNT_W-1:0] sec_cnt;
  logic             wait_entry;

  assign wait_entry = (state == ST_IDLE) && (en_attack_p1 || en_attack_p2);

  // Driven from the next-state conditions so the count reads 0 exactly when
  // the FSM is outside the WAIT states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds_left <= 5'd0;
      sec_cnt      <= '0;
    end else if (wait_entry) begin
      seconds_left <= 5'(SECS);
      sec_cnt      <= '0;
    end else if (wait_stay) begin
      if (sec_cnt == SEC_LAST) begin
        sec_cnt <= '0;
        if (seconds_left != 5'd0) begin
          seconds_left <= seconds_left - 5'd1;
        end
      end else begin
        sec_cnt <= sec_cnt + CNT_W'(1);
      end
    end else begin
      seconds_left <= 5'd0;
      sec_cnt      <= '0;
    end
  end
`else
  logic unused_wait_stay;
  assign unused_wait_stay = wait_stay;
`endif

endmodule

// File: tb/tb_attack_responder.sv
// Testbench for attack_responder: directed stimulus, expected shots pushed to
// a scoreboard queue and checked by a monitor whenever the DUT pulses.

module tb_attack_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_attack_p1 = 1'b0;
  logic       en_attack_p2 = 1'b0;
  logic       en_attack_random = 1'b0;
  logic       en_check = 1'b0;
  logic       fire_p1 = 1'b0;
  logic       fire_p2 = 1'b0;
  logic [5:0] target = 6'd0;
  logic       end_attack_p1;
  logic       end_attack_p2;
  logic       timeout;
  logic [1:0] current_player;
  logic [2:0] attack_row;
  logic [2:0] attack_col;
  logic       attack_valid;

  always #5 clk = ~clk;

  attack_responder #(
    .BOARD_N(5),
    .TIMEOUT_CYCLES(20),
    .CNT_W(30),
    .LFSR_SEED(6'h2B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_attack_p1(en_attack_p1),
    .en_attack_p2(en_attack_p2),
    .en_attack_random(en_attack_random),
    .en_check(en_check),
    .fire_p1(fire_p1),
    .fire_p2(fire_p2),
    .target(target),
    .end_attack_p1(end_attack_p1),
    .end_attack_p2(end_attack_p2),
    .timeout(timeout),
    .current_player(current_player),
    .attack_row(attack_row),
    .attack_col(attack_col),
    .attack_valid(attack_valid)
  );

  typedef struct {
    logic [1:0] who;   // {p2, p1}
    logic       rnd;   // random shot: only on-board range is known
    logic [2:0] row;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] who, input logic rnd,
                          input logic [2:0] row, input logic [2:0] col);
    exp_t e;
    e.who = who;
    e.rnd = rnd;
    e.row = row;
    e.col = col;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits a bounded number of cycles for a random shot to appear.
  task automatic wait_random(input string name);
    int n;
    n = 0;
    while (!(end_attack_p1 || end_attack_p2) && n < 64) begin
      tick();
      n++;
    end
    check({name, "_within_63"}, 32'(end_attack_p1 || end_attack_p2), 32'd1);
    check({name, "_timeout_low"}, 32'(timeout), 32'd0);
    en_attack_random = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (end_attack_p1 || end_attack_p2 || attack_valid) begin
        check("pulse_one_cycle", 32'(prev_pulse), 32'd0);
        check("valid_with_end", 32'(attack_valid), 32'(end_attack_p1 | end_attack_p2));
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({end_attack_p2, end_attack_p1, attack_valid}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("who", 32'({end_attack_p2, end_attack_p1}), 32'(mon_e.who));
          if (mon_e.rnd) begin
            check("rnd_row_on_board", 32'(attack_row < 3'd5), 32'd1);
            check("rnd_col_on_board", 32'(attack_col < 3'd5), 32'd1);
          end else begin
            check("row", 32'(attack_row), 32'(mon_e.row));
            check("col", 32'(attack_col), 32'(mon_e.col));
          end
        end
      end
      prev_pulse = end_attack_p1 | end_attack_p2 | attack_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_end_p1", 32'(end_attack_p1), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_player", 32'(current_player), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_player", 32'(current_player), 32'd0);
    check("post_rst_row_col", 32'({attack_row, attack_col}), 32'd0);
    check("post_rst_valid", 32'(attack_valid), 32'd0);

    // P1 valid shot at row 2, col 3
    en_attack_p1 = 1'b1;
    tick();
    check("p1_player", 32'(current_player), 32'd1);
    fire_p1 = 1'b1;
    target = 6'o23;
    push_exp(2'b01, 1'b0, 3'd2, 3'd3);
    tick();
    check("p1_end", 32'(end_attack_p1), 32'd1);
    fire_p1 = 1'b0;
    en_attack_p1 = 1'b0;
    tick();
    check("p1_end_one_cycle", 32'(end_attack_p1), 32'd0);
    check("p1_player_held", 32'(current_player), 32'd1);

    // Out-of-range and wrong-player fire in WAIT_P2, then valid shot
    en_attack_p2 = 1'b1;
    tick();
    check("p2_player", 32'(current_player), 32'd2);
    fire_p2 = 1'b1;
    target = 6'o52;
    tick();
    fire_p2 = 1'b0;
    fire_p1 = 1'b1;
    target = 6'o11;
    tick();
    fire_p1 = 1'b0;
    tick();
    check("p2_no_end_bad_fire", 32'({end_attack_p2, end_attack_p1}), 32'd0);
    fire_p2 = 1'b1;
    target = 6'o44;
    push_exp(2'b10, 1'b0, 3'd4, 3'd4);
    tick();
    check("p2_end", 32'(end_attack_p2), 32'd1);
    fire_p2 = 1'b0;
    en_attack_p2 = 1'b0;
    tick();

    // Timeout in WAIT_P1, then random shot credited to p1
    en_attack_p1 = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      tick();
      check("to_early", 32'(timeout), 32'd0);
    end
    tick();
    check("to_on_20", 32'(timeout), 32'd1);
    en_attack_p1 = 1'b0;
    repeat (3) tick();
    check("to_held", 32'(timeout), 32'd1);
    fire_p1 = 1'b1;
    target = 6'o11;
    tick();
    fire_p1 = 1'b0;
    tick();
    check("to_fire_ignored", 32'(end_attack_p1), 32'd0);
    check("to_still_held", 32'(timeout), 32'd1);
    en_attack_random = 1'b1;
    push_exp(2'b01, 1'b1, 3'd0, 3'd0);
    tick();
    check("to_cleared", 32'(timeout), 32'd0);
    wait_random("rand_p1");
    tick();

    // Terminal-cycle race: valid fire on the last timer cycle wins
    en_attack_p1 = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      tick();
      check("race_early", 32'(timeout), 32'd0);
    end
    fire_p1 = 1'b1;
    target = 6'o40;
    push_exp(2'b01, 1'b0, 3'd4, 3'd0);
    tick();
    check("race_end", 32'(end_attack_p1), 32'd1);
    check("race_no_timeout", 32'(timeout), 32'd0);
    fire_p1 = 1'b0;
    en_attack_p1 = 1'b0;
    tick();
    check("race_still_no_timeout", 32'(timeout), 32'd0);

    // Enable drop after 5 cycles, then re-entry restarts the timer
    en_attack_p2 = 1'b1;
    tick();
    repeat (5) tick();
    en_attack_p2 = 1'b0;
    tick();
    tick();
    check("drop_no_timeout", 32'(timeout), 32'd0);
    check("drop_player", 32'(current_player), 32'd2);
    en_attack_p2 = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      tick();
      check("reentry_early", 32'(timeout), 32'd0);
    end
    tick();
    check("reentry_timeout", 32'(timeout), 32'd1);
    en_attack_p2 = 1'b0;
    en_attack_random = 1'b1;
    push_exp(2'b10, 1'b1, 3'd0, 3'd0);
    tick();
    wait_random("rand_p2");
    tick();

    // Asynchronous reset in the middle of WAIT_P1
    en_attack_p1 = 1'b1;
    repeat (4) tick();
    check("pre_rst_player", 32'(current_player), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_player", 32'(current_player), 32'd0);
    check("midrst_row_col", 32'({attack_row, attack_col}), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    en_attack_p1 = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("after_rst_player", 32'(current_player), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
